// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared widths, FSM states and saturation limits for the FIR MAC lanes
package fir_pkg;

  localparam int DW   = 16;
  localparam int NTAP = 10;
  localparam int PW   = 2 * DW;
  localparam int ACCW = 2 * DW + 4;
  localparam int KW   = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } fir_state_e;

  localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'((longint'(1) <<< (DW - 1)) - 1);
  localparam logic signed [ACCW-1:0] SAT_MIN = ~SAT_MAX;

endpackage

// File: rtl/fir_coeff_ram.sv
// rtl/fir_coeff_ram.sv - NTAP x DW coefficient register file, one write port, one combinational read port
module fir_coeff_ram
  import fir_pkg::*;
#(
  parameter int NTAP = fir_pkg::NTAP
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [KW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [KW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [NTAP];

  // Addresses at or above NTAP decode to no entry, so such writes fall away.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NTAP; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      for (int i = 0; i < NTAP; i++) begin
        if (waddr_i == KW'(i)) mem_q[i] <= wdata_i;
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < NTAP; i++) begin
      if (raddr_i == KW'(i)) rdata_o = mem_q[i];
    end
  end

endmodule

// File: rtl/fir_mac_lane.sv
// rtl/fir_mac_lane.sv - one FIR MAC lane: delay-line slice, coefficient bank, sequential multiply-accumulate
// FIR_MAC_ROUND_EN: round half toward +inf before the output shift instead of flooring.
module fir_mac_lane
  import fir_pkg::*;
#(
  parameter int NTAP      = fir_pkg::NTAP,
  parameter int OUT_SHIFT = 15
) (
  input  logic          iClk12M,
  input  logic          iRst,
  input  logic          iEnSample600k,
  input  logic [DW-1:0] iSample,
  input  logic          iCoeffWr,
  input  logic [3:0]    iCoeffAddr,
  input  logic [DW-1:0] iCoeffData,
  output logic [DW-1:0] oDelayOut,
  output logic [DW-1:0] oMac,
  output logic          oMacValid,
  output logic          oBusy,
  output logic          oOverrun
);

  fir_state_e             state_q, state_d;
  logic [KW-1:0]          k_q, k_d;
  logic signed [PW-1:0]   prod_q, prod_d;
  logic                   prod_vld_q, prod_vld_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic [DW-1:0]          mac_q, mac_d;
  logic                   mac_vld_q, mac_vld_d;
  logic                   ovr_q, ovr_d;
  logic [DW-1:0]          delay_q [NTAP];
  logic [DW-1:0]          tap_sample;
  logic [DW-1:0]          tap_coef;
  logic signed [ACCW-1:0] acc_rnd;
  logic signed [ACCW-1:0] acc_sh;
  logic [DW-1:0]          result;

  always_ff @(posedge iClk12M or posedge iRst) begin
    if (iRst) begin
      for (int i = 0; i < NTAP; i++) delay_q[i] <= '0;
    end else if (iEnSample600k) begin
      delay_q[0] <= iSample;
      for (int i = 1; i < NTAP; i++) delay_q[i] <= delay_q[i-1];
    end
  end

  fir_coeff_ram #(
    .NTAP(NTAP)
  ) u_coeff_ram (
    .clk_i  (iClk12M),
    .rst_i  (iRst),
    .we_i   (iCoeffWr),
    .waddr_i({1'b0, iCoeffAddr}),
    .wdata_i(iCoeffData),
    .raddr_i(k_q),
    .rdata_o(tap_coef)
  );

  always_comb begin
    tap_sample = '0;
    for (int i = 0; i < NTAP; i++) begin
      if (k_q == KW'(i)) tap_sample = delay_q[i];
    end
  end

`ifdef FIR_MAC_ROUND_EN
  localparam logic signed [ACCW-1:0] RND_C = ACCW'((64'd1 << OUT_SHIFT) >> 1);
  assign acc_rnd = acc_q + RND_C;
`else
  assign acc_rnd = acc_q;
`endif

  assign acc_sh = acc_rnd >>> OUT_SHIFT;

  always_comb begin
    if (acc_sh > SAT_MAX)      result = SAT_MAX[DW-1:0];
    else if (acc_sh < SAT_MIN) result = SAT_MIN[DW-1:0];
    else                       result = acc_sh[DW-1:0];
  end

  // Product register is one stage ahead of the accumulator; DRAIN folds in the last one.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    prod_d     = prod_q;
    prod_vld_d = 1'b0;
    acc_d      = prod_vld_q ? acc_q + ACCW'(prod_q) : acc_q;
    mac_d      = mac_q;
    mac_vld_d  = 1'b0;
    ovr_d      = ovr_q;
    if (iEnSample600k) begin
      state_d = MAC;
      k_d     = '0;
      acc_d   = '0;
      if (state_q != IDLE) ovr_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: ;
        MAC: begin
          prod_d     = PW'($signed(tap_sample)) * PW'($signed(tap_coef));
          prod_vld_d = 1'b1;
          k_d        = k_q + KW'(1);
          if (k_q == KW'(NTAP - 1)) state_d = DRAIN;
        end
        DRAIN: state_d = OUT;
        OUT: begin
          mac_d     = result;
          mac_vld_d = 1'b1;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge iClk12M or posedge iRst) begin
    if (iRst) begin
      state_q    <= IDLE;
      k_q        <= '0;
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      acc_q      <= '0;
      mac_q      <= '0;
      mac_vld_q  <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      prod_q     <= prod_d;
      prod_vld_q <= prod_vld_d;
      acc_q      <= acc_d;
      mac_q      <= mac_d;
      mac_vld_q  <= mac_vld_d;
      ovr_q      <= ovr_d;
    end
  end

  assign oDelayOut = delay_q[NTAP-1];
  assign oMac      = mac_q;
  assign oMacValid = mac_vld_q;
  assign oBusy     = (state_q != IDLE);
  assign oOverrun  = ovr_q;

endmodule

// File: tb/tb_fir_mac_lane.sv
// tb/tb_fir_mac_lane.sv - scoreboard bench for fir_mac_lane against a tap-sum reference model
module tb_fir_mac_lane;

  localparam int NT  = 10;
  localparam int OSH = 1;

  logic        clk;
  logic        rst;
  logic        stb;
  logic [15:0] smp;
  logic        we;
  logic [3:0]  waddr;
  logic [15:0] wdata;
  logic [15:0] oDelayOut;
  logic [15:0] oMac;
  logic        oMacValid;
  logic        oBusy;
  logic        oOverrun;

  fir_mac_lane #(
    .NTAP     (NT),
    .OUT_SHIFT(OSH)
  ) dut (
    .iClk12M      (clk),
    .iRst         (rst),
    .iEnSample600k(stb),
    .iSample      (smp),
    .iCoeffWr     (we),
    .iCoeffAddr   (waddr),
    .iCoeffData   (wdata),
    .oDelayOut    (oDelayOut),
    .oMac         (oMac),
    .oMacValid    (oMacValid),
    .oBusy        (oBusy),
    .oOverrun     (oOverrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] val;
    int          at_edge;
    logic [15:0] dout;
    bit          ovr;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] m_dly [NT];
  logic [15:0] m_cf  [NT];
  bit          job_act;
  int          job_t;
  longint      job_sum;
  bit          m_ovr;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [15:0] lane_result(input longint s);
    longint r;
    r = s;
`ifdef FIR_MAC_ROUND_EN
    if (OSH > 0) r = r + (longint'(1) << (OSH - 1));
`endif
    r = r >>> OSH;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r[15:0];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NT; i++) begin
      m_dly[i] = '0;
      m_cf[i]  = '0;
    end
    job_act = 0;
    job_sum = 0;
    m_ovr   = 0;
    exp_q.delete();
  endtask

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (edge %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference: sum of delay[k]*coef[k], tap k read one edge per tap after the strobe.
  always @(posedge clk) begin
    int d;
    cyc++;
    if (rst) begin
      model_clear();
    end else begin
      if (stb) begin
        if (job_act) m_ovr = 1;
        for (int i = NT - 1; i > 0; i--) m_dly[i] = m_dly[i-1];
        m_dly[0] = smp;
        job_act = 1;
        job_t   = cyc;
        job_sum = 0;
      end else if (job_act) begin
        d = cyc - job_t;
        if (d >= 1 && d <= NT)
          job_sum += longint'($signed(m_dly[d-1])) * longint'($signed(m_cf[d-1]));
        if (d == NT + 2) begin
          exp_q.push_back('{lane_result(job_sum), cyc, m_dly[NT-1], m_ovr});
          job_act = 0;
        end
      end
      if (we && int'(waddr) < NT) m_cf[waddr] = wdata;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && oMacValid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: actual pulse oMac=%0h required no pulse (edge %0d)", oMac, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("mac_value", oMac, e.val);
        chk("mac_latency_edge", cyc, e.at_edge);
        chk("delay_out", oDelayOut, e.dout);
        chk("overrun_at_pulse", oOverrun, e.ovr);
      end
    end
  end

  task automatic tick(input logic s, input logic [15:0] x, input logic w,
                      input logic [3:0] a, input logic [15:0] dt);
    @(negedge clk);
    stb = s; smp = x; we = w; waddr = a; wdata = dt;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 16'h0, 0, 4'h0, 16'h0);
  endtask

  task automatic strobe(input logic [15:0] x, input int gap);
    tick(1, x, 0, 4'h0, 16'h0);
    idle(gap - 1);
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] dt);
    tick(0, 16'h0, 1, a, dt);
  endtask

  int          gap;
  logic        wsel;
  logic [15:0] xs;

  initial begin
    rst = 1'b1; stb = 0; smp = 0; we = 0; waddr = 0; wdata = 0;
    model_clear();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_mac", oMac, 0);
    chk("reset_valid", oMacValid, 0);
    chk("reset_busy", oBusy, 0);
    chk("reset_overrun", oOverrun, 0);
    chk("reset_delay_out", oDelayOut, 0);

    // impulse: coef 2(k+1) with a 1-bit shift yields 1..10 then 0
    for (int k = 0; k < NT; k++) wr(4'(k), 16'(2 * (k + 1)));
    strobe(16'h0001, 20);
    for (int i = 0; i < 11; i++) strobe(16'h0000, 20);

    for (int k = 0; k < NT; k++) wr(4'(k), 16'h7fff);
    for (int i = 0; i < NT; i++) strobe(16'h7fff, 20);
    for (int i = 0; i < NT; i++) strobe(16'h8000, 20);

    wr(4'd0, 16'd3);
    for (int k = 1; k < NT; k++) wr(4'(k), 16'h0);
    strobe(16'h0001, 20);
    strobe(16'hffff, 20);

    for (int k = 0; k < NT; k++) wr(4'(k), 16'(k * 7 - 20));
    strobe(16'd100, 5);
    strobe(16'd37, 20);
    chk("overrun_sticky", oOverrun, 1);

    tick(1, 16'd55, 0, 4'h0, 16'h0);
    idle(2);
    wr(4'd9, 16'd1234);
    wr(4'd12, 16'h5a5a);
    idle(15);
    strobe(16'hfff0, 20);

    tick(1, 16'd77, 0, 4'h0, 16'h0);
    idle(3);
    @(negedge clk);
    chk("busy_mid_mac", oBusy, 1);
    #2 rst = 1'b1;
    model_clear();
    #1;
    chk("rst_mid_mac", oMac, 0);
    chk("rst_mid_valid", oMacValid, 0);
    chk("rst_mid_busy", oBusy, 0);
    chk("rst_mid_overrun", oOverrun, 0);
    chk("rst_mid_delay", oDelayOut, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(20);

    for (int it = 0; it < 40; it++) begin
      gap = $urandom_range(6, 24);
      for (int c = 0; c < gap; c++) begin
        wsel = ($urandom_range(0, 2) == 0);
        xs = (it % 3 == 0) ? 16'($urandom) : 16'($urandom_range(0, 255) - 128);
        tick(c == 0, (c == 0) ? xs : 16'h0, wsel, 4'($urandom_range(0, 15)),
             16'($urandom_range(0, 127) - 64));
      end
    end

    idle(30);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("overrun_final", oOverrun, m_ovr);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
